// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and types for the first-word-fall-through FIFO.
//   clog2      - ceil(log2(v)), 0 for v <= 1
//   clog2s     - bits needed to represent v
//   ptr_t      - widest pointer container; users slice to their own pointer width
//   out_state_e - occupancy of the 2-entry output stage (EMPTY, ONE, TWO)
package fifo_pkg;

    localparam int unsigned PTR_MAX_W = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } out_state_e;

    // Ceiling log2; used to round the depth up to a power of two.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = (value > 32'd0) ? value - 32'd1 : 32'd0;
        r = 32'd0;
        while (v > 32'd0) begin
            r = r + 32'd1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Number of bits needed to hold the value itself.
    function automatic int unsigned clog2s(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = value;
        r = 32'd0;
        while (v > 32'd0) begin
            r = r + 32'd1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ram_1clk_1w_1r.sv
// ram_1clk_1w_1r: simple dual-port RAM, one write port and one registered read port.
//   CLK     - clock
//   WR_EN   - write strobe, WR_DATA stored at WR_ADDR
//   RD_EN   - read strobe, RD_DATA updated with mem[RD_ADDR] on the next edge
//   RD_DATA - registered read data (1-cycle latency), holds when RD_EN is low
module ram_1clk_1w_1r
    import fifo_pkg::*;
#(
    parameter  int unsigned C_WIDTH  = 32,
    parameter  int unsigned C_DEPTH  = 512,
    localparam int unsigned C_ADDR_W = clog2(C_DEPTH)
) (
    input  logic                CLK,
    input  logic                WR_EN,
    input  logic [C_ADDR_W-1:0] WR_ADDR,
    input  logic [C_WIDTH-1:0]  WR_DATA,
    input  logic                RD_EN,
    input  logic [C_ADDR_W-1:0] RD_ADDR,
    output logic [C_WIDTH-1:0]  RD_DATA
);

    logic [C_WIDTH-1:0] mem_q [C_DEPTH];
    logic [C_WIDTH-1:0] rd_data_q;

    // Storage array and read register carry no reset; validity is tracked by the owner.
    always_ff @(posedge CLK) begin
        if (WR_EN) begin
            mem_q[WR_ADDR] <= WR_DATA;
        end
        if (RD_EN) begin
            rd_data_q <= mem_q[RD_ADDR];
        end
    end

    assign RD_DATA = rd_data_q;

endmodule

// File: rtl/fifo_fwft_prog.sv
// fifo_fwft_prog: single-clock first-word-fall-through FIFO with occupancy count,
// programmable almost-full / almost-empty flags and optional sticky error flags.
// Optional feature macro: FIFO_FWFT_ERR_EN (sticky ERR_OVF / ERR_UDF; tied 0 otherwise).
//   CLK, RST         - clock, asynchronous active-high reset
//   WR_DATA, WR_EN   - write side; dropped while WR_FULL
//   WR_FULL          - RAM holds C_REAL_DEPTH words
//   WR_AFULL         - COUNT >= C_AFULL
//   RD_DATA, RD_EN   - head word (valid while RD_EMPTY low), consume strobe
//   RD_EMPTY         - no valid head word
//   RD_AEMPTY        - COUNT <= C_AEMPTY
//   COUNT            - words accepted and not yet consumed (RAM + output stage)
//   ERR_OVF, ERR_UDF - sticky rejected-write / rejected-read indicators
module fifo_fwft_prog
    import fifo_pkg::*;
#(
    parameter  int unsigned C_WIDTH      = 32,
    parameter  int unsigned C_DEPTH      = 512,
    parameter  int unsigned C_AFULL      = (32'd1 << clog2(C_DEPTH)) - 32'd4,
    parameter  int unsigned C_AEMPTY     = 4,
    localparam int unsigned C_COUNT_BITS = clog2s((32'd1 << clog2(C_DEPTH)) + 32'd3)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [C_WIDTH-1:0]      WR_DATA,
    input  logic                    WR_EN,
    output logic                    WR_FULL,
    output logic                    WR_AFULL,
    output logic [C_WIDTH-1:0]      RD_DATA,
    input  logic                    RD_EN,
    output logic                    RD_EMPTY,
    output logic                    RD_AEMPTY,
    output logic [C_COUNT_BITS-1:0] COUNT,
    output logic                    ERR_OVF,
    output logic                    ERR_UDF
);

    localparam int unsigned C_REAL_DEPTH = 32'd1 << clog2(C_DEPTH);
    localparam int unsigned ADDR_W       = clog2(C_REAL_DEPTH);
    localparam int unsigned PTR_W        = ADDR_W + 32'd1;

    localparam logic [C_COUNT_BITS-1:0] AFULL_LVL  = C_COUNT_BITS'(C_AFULL);
    localparam logic [C_COUNT_BITS-1:0] AEMPTY_LVL = C_COUNT_BITS'(C_AEMPTY);

    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic                    full_q, full_d;
    logic                    rd_vld_q, rd_vld_d;
    out_state_e              state_q, state_d;
    logic [C_WIDTH-1:0]      head_q, head_d;
    logic [C_WIDTH-1:0]      cache_q, cache_d;
    logic [C_COUNT_BITS-1:0] count_q, count_d;
    logic                    afull_q, afull_d;
    logic                    aempty_q, aempty_d;
    logic                    empty_q, empty_d;

    logic                    ram_empty_c;
    logic                    wr_acc_c;
    logic                    rd_acc_c;
    logic                    ram_rd_c;
    logic [1:0]              held_c;
    logic [C_WIDTH-1:0]      ram_dout;

    assign ram_empty_c = (wr_ptr_q == rd_ptr_q);
    assign wr_acc_c    = WR_EN & ~full_q;
    assign rd_acc_c    = RD_EN & ~empty_q;

    // Words held in the output stage plus the one possibly arriving from the RAM.
    always_comb begin
        held_c = 2'd0;
        case (state_q)
            ONE:     held_c = 2'd1;
            TWO:     held_c = 2'd2;
            default: held_c = 2'd0;
        endcase
        held_c = held_c + 2'(rd_vld_q);
    end

    // Prefetch keeps at most two words in the stage + in flight, unless the head is leaving.
    assign ram_rd_c = ~ram_empty_c & (RD_EN | (held_c < 2'd2));

    ram_1clk_1w_1r #(
        .C_WIDTH (C_WIDTH),
        .C_DEPTH (C_REAL_DEPTH)
    ) u_ram (
        .CLK     (CLK),
        .WR_EN   (wr_acc_c),
        .WR_ADDR (wr_ptr_q[ADDR_W-1:0]),
        .WR_DATA (WR_DATA),
        .RD_EN   (ram_rd_c),
        .RD_ADDR (rd_ptr_q[ADDR_W-1:0]),
        .RD_DATA (ram_dout)
    );

    // Next-state: pointers, count, flags and the output-stage FSM.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(wr_acc_c);
        rd_ptr_d = rd_ptr_q + PTR_W'(ram_rd_c);
        rd_vld_d = ram_rd_c;
        count_d  = count_q + C_COUNT_BITS'(wr_acc_c) - C_COUNT_BITS'(rd_acc_c);
        state_d  = state_q;
        head_d   = head_q;
        cache_d  = cache_q;

        // Cache always drains into the head ahead of newly arriving RAM data.
        case (state_q)
            EMPTY: begin
                if (rd_vld_q) begin
                    head_d  = ram_dout;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (rd_acc_c) begin
                    if (rd_vld_q) begin
                        head_d = ram_dout;
                    end else begin
                        state_d = EMPTY;
                    end
                end else if (rd_vld_q) begin
                    cache_d = ram_dout;
                    state_d = TWO;
                end
            end
            TWO: begin
                if (rd_acc_c) begin
                    head_d = cache_q;
                    if (rd_vld_q) begin
                        cache_d = ram_dout;
                    end else begin
                        state_d = ONE;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase

        full_d   = (wr_ptr_d[PTR_W-1] != rd_ptr_d[PTR_W-1]) &&
                   (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]);
        empty_d  = (state_d == EMPTY);
        afull_d  = (count_d >= AFULL_LVL);
        aempty_d = (count_d <= AEMPTY_LVL);
    end

    // State registers; reset discards any in-flight RAM read via rd_vld_q.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            rd_vld_q <= 1'b0;
            state_q  <= EMPTY;
            head_q   <= '0;
            cache_q  <= '0;
            count_q  <= '0;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            rd_vld_q <= rd_vld_d;
            state_q  <= state_d;
            head_q   <= head_d;
            cache_q  <= cache_d;
            count_q  <= count_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            empty_q  <= empty_d;
        end
    end

    assign WR_FULL   = full_q;
    assign WR_AFULL  = afull_q;
    assign RD_DATA   = head_q;
    assign RD_EMPTY  = empty_q;
    assign RD_AEMPTY = aempty_q;
    assign COUNT     = count_q;

`ifdef FIFO_FWFT_ERR_EN
    logic err_ovf_q, err_ovf_d;
    logic err_udf_q, err_udf_d;

    // Sticky error flags, cleared only by reset.
    always_comb begin
        err_ovf_d = err_ovf_q | (WR_EN & full_q);
        err_udf_d = err_udf_q | (RD_EN & empty_q);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
        end else begin
            err_ovf_q <= err_ovf_d;
            err_udf_q <= err_udf_d;
        end
    end

    assign ERR_OVF = err_ovf_q;
    assign ERR_UDF = err_udf_q;
`else
    assign ERR_OVF = 1'b0;
    assign ERR_UDF = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_fwft_prog.sv
// tb_fifo_fwft_prog: scoreboard bench for fifo_fwft_prog (W=8, DEPTH=8, AFULL=6, AEMPTY=1).
// Driver pushes every accepted write into exp_q; the negedge monitor checks the head word
// against the queue front whenever RD_EMPTY is low and checks COUNT / flags every cycle.
module tb_fifo_fwft_prog;

    localparam int unsigned W      = 8;
    localparam int unsigned CAP    = 10;
    localparam int unsigned RAMCAP = 8;
    localparam int unsigned AFULL  = 6;
    localparam int unsigned AEMPTY = 1;
`ifdef FIFO_FWFT_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] wr_data;
    logic         wr_en;
    logic         wr_full;
    logic         wr_afull;
    logic [W-1:0] rd_data;
    logic         rd_en;
    logic         rd_empty;
    logic         rd_aempty;
    logic [3:0]   count;
    logic         err_ovf;
    logic         err_udf;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] exp_q[$];
    int           m_cnt = 0;
    bit           m_ovf = 1'b0;
    bit           m_udf = 1'b0;

    always #5 clk = ~clk;

    fifo_fwft_prog #(
        .C_WIDTH  (8),
        .C_DEPTH  (8),
        .C_AFULL  (6),
        .C_AEMPTY (1)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .WR_DATA   (wr_data),
        .WR_EN     (wr_en),
        .WR_FULL   (wr_full),
        .WR_AFULL  (wr_afull),
        .RD_DATA   (rd_data),
        .RD_EN     (rd_en),
        .RD_EMPTY  (rd_empty),
        .RD_AEMPTY (rd_aempty),
        .COUNT     (count),
        .ERR_OVF   (err_ovf),
        .ERR_UDF   (err_udf)
    );

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Drive one cycle of stimulus just after the active edge; record accepted writes.
    task automatic step(input bit w, input logic [W-1:0] d, input bit r);
        @(posedge clk);
        #1;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        if (w && !wr_full && !rst) exp_q.push_back(d);
    endtask

    // Monitor: reference model of count / flags / ordering, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_cnt = 0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            chk("count", int'(count), m_cnt);
            chk("wr_afull", int'(wr_afull), int'(m_cnt >= int'(AFULL)));
            chk("rd_aempty", int'(rd_aempty), int'(m_cnt <= int'(AEMPTY)));
            if (m_cnt == 0) chk("empty_when_zero", int'(rd_empty), 1);
            if (m_cnt == int'(CAP)) chk("full_at_capacity", int'(wr_full), 1);
            if (wr_full) chk("full_needs_ram_full", int'(m_cnt >= int'(RAMCAP)), 1);
            chk("err_ovf", int'(err_ovf), int'(m_ovf));
            chk("err_udf", int'(err_udf), int'(m_udf));
            if (!rd_empty) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rd_data_spurious: got word %0d, expected none (t=%0t)", rd_data, $time);
                end else begin
                    chk("rd_data", int'(rd_data), int'(exp_q[0]));
                    if (rd_en) void'(exp_q.pop_front());
                end
            end
            if (wr_en && !wr_full) m_cnt++;
            if (rd_en && !rd_empty) m_cnt--;
            if (ERR_EN && wr_en && wr_full) m_ovf = 1'b1;
            if (ERR_EN && rd_en && rd_empty) m_udf = 1'b1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_count", int'(count), 0);
        chk("rst_rd_empty", int'(rd_empty), 1);
        chk("rst_rd_aempty", int'(rd_aempty), 1);
        chk("rst_wr_full", int'(wr_full), 0);
        chk("rst_wr_afull", int'(wr_afull), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        step(1'b0, '0, 1'b0);

        // First-word latency: write in cycle 0, head visible in cycle 3.
        step(1'b1, 8'hA5, 1'b0);
        @(negedge clk) chk("lat_c0_empty", int'(rd_empty), 1);
        step(1'b0, '0, 1'b0);
        @(negedge clk) chk("lat_c1_empty", int'(rd_empty), 1);
        step(1'b0, '0, 1'b0);
        @(negedge clk) chk("lat_c2_empty", int'(rd_empty), 1);
        step(1'b0, '0, 1'b0);
        @(negedge clk);
        chk("lat_c3_empty", int'(rd_empty), 0);
        chk("lat_c3_data", int'(rd_data), 32'hA5);
        chk("lat_c3_count", int'(count), 1);
        chk("lat_c3_aempty", int'(rd_aempty), 1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        @(negedge clk) chk("lat_consumed_empty", int'(rd_empty), 1);

        // Capacity: 10 writes accepted, the 11th rejected.
        for (int i = 0; i <= 10; i++) begin
            step(1'b1, W'(i), 1'b0);
            @(negedge clk) chk("cap_full_flag", int'(wr_full), int'(i == 10));
        end
        step(1'b0, '0, 1'b0);
        @(negedge clk);
        chk("cap_count", int'(count), 10);
        chk("cap_full_hold", int'(wr_full), 1);

        // Drain at one word per cycle in write order.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, '0, 1'b1);
            @(negedge clk);
            chk("drain_not_empty", int'(rd_empty), 0);
            chk("drain_data", int'(rd_data), i);
        end
        step(1'b0, '0, 1'b0);
        @(negedge clk);
        chk("drain_done_empty", int'(rd_empty), 1);
        chk("drain_done_count", int'(count), 0);

        // Level sweep through the almost-full / almost-empty thresholds.
        for (int i = 0; i < 7; i++) begin
            step(1'b1, W'($urandom), 1'b0);
            step(1'b0, '0, 1'b0);
            @(negedge clk) chk("sweep_afull", int'(wr_afull), int'(i + 1 >= 6));
        end
        for (int i = 0; i < 7; i++) begin
            step(1'b0, '0, 1'b1);
            step(1'b0, '0, 1'b0);
            @(negedge clk) chk("sweep_aempty", int'(rd_aempty), int'(6 - i <= 1));
        end

        // Read while empty, then reset in the middle of a write burst.
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        @(negedge clk) chk("udf_sticky", int'(err_udf), int'(ERR_EN));
        for (int i = 0; i < 5; i++) step(1'b1, W'(8'h50 + i), 1'b0);
        repeat (4) step(1'b0, '0, 1'b0);
        @(negedge clk) chk("pre_rst_count", int'(count), 5);
        step(1'b1, 8'h60, 1'b0);
        step(1'b1, 8'h61, 1'b0);
        @(posedge clk);
        #1;
        rst   = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(negedge clk);
        chk("mid_rst_count", int'(count), 0);
        chk("mid_rst_empty", int'(rd_empty), 1);
        chk("mid_rst_err_ovf", int'(err_ovf), 0);
        chk("mid_rst_err_udf", int'(err_udf), 0);
        chk("mid_rst_rd_data", int'(rd_data), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, '0, 1'b0);
            @(negedge clk) chk("post_rst_no_stale", int'(rd_empty), 1);
        end
        step(1'b1, 8'h3C, 1'b0);
        begin
            int k;
            k = 0;
            while (rd_empty && k < 10) begin
                step(1'b0, '0, 1'b0);
                k++;
            end
            chk("post_rst_word_timeout", int'(k < 10), 1);
        end
        @(negedge clk) chk("post_rst_word", int'(rd_data), 32'h3C);
        step(1'b0, '0, 1'b1);

        // Random simultaneous traffic across pointer wrap.
        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 3) != 0), W'($urandom), 1'($urandom_range(0, 1)));
        end
        for (int k = 0; k < 40 && exp_q.size() > 0; k++) begin
            step(1'b0, '0, !rd_empty);
        end
        step(1'b0, '0, 1'b0);
        chk("final_drain_left", exp_q.size(), 0);
        step(1'b0, '0, 1'b0);
        @(negedge clk) chk("final_count", int'(count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
